alu_arbiter: RTL and testbench
==============================

ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter: none; all widths fixed (data 16 bits, opcode 4 bits).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 req0_valid, req1_valid  input  1 each  requester N presents an operation.
REQ-005 req0_ready, req1_ready  output  1 each  operation accepted this cycle.
REQ-006 req0_op, req1_op  input  4 each  ALU opcode: 0001 ADD, 0010 SUB, 0011 AND, 0100 OR, 0101 XOR, 0110 NOT a, 0111 SHL a, 1000 SHR a, 1001 LT, 1010 EQ.
REQ-007 req0_a, req0_b, req1_a, req1_b  input  16 each  operands.
REQ-008 rsp0_valid, rsp1_valid  output  1 each  result available for requester N.
REQ-009 rsp0_ack, rsp1_ack  input  1 each  requester N consumes its result.
REQ-010 rsp_result  output  16  captured ALU result (shared by both response ports).
REQ-011 rsp_zero  output  1  captured ALU zero flag.
REQ-012 alu_enable  output  1  enable to the shared ALU.
REQ-013 alu_op  output  4  opcode to the ALU.
REQ-014 alu_a, alu_b  output  16 each  operands to the ALU.
REQ-015 alu_result  input  16; alu_zero  input  1  combinational ALU outputs.
REQ-016 busy  output  1  high in any state other than IDLE.
REQ-017 op_count  output  16  number of completed operations.

Function
REQ-018 FSM states: IDLE, EXEC, RESP.
REQ-019 Priority pointer prio (1 bit) names the favoured requester; when both valids are high in IDLE, grant goes to prio, otherwise to the single valid requester.
REQ-020 reqN_ready is combinational: 1 only in IDLE for the granted requester, 0 otherwise; at most one ready is high per cycle.
REQ-021 Accept (IDLE, reqN_valid and reqN_ready) registers op/a/b into alu_op/alu_a/alu_b, records grant owner, and moves to EXEC next cycle.
REQ-022 EXEC lasts exactly one cycle with alu_enable=1; at its closing edge alu_result and alu_zero are registered into rsp_result and rsp_zero, and the state moves to RESP.
REQ-023 RESP drives rspN_valid=1 for the owner only; rsp_result, rsp_zero and alu_* remain stable until rspN_ack.
REQ-024 RESP with owner's ack: next cycle go to IDLE, set prio to the non-owner, increment op_count (mod 2^16, wraps 0xFFFF to 0x0000).
REQ-025 Ack from the non-owner, or any ack outside RESP, is ignored.
REQ-026 Minimum latency accept-to-rsp_valid: 2 cycles; minimum issue interval: 3 cycles (ack in the first RESP cycle).
REQ-027 alu_enable is 0 in IDLE and RESP; alu_op/alu_a/alu_b hold their last accepted values outside EXEC.
REQ-028 Undefined opcodes (0000, 1011-1111) are forwarded unchanged; the response carries whatever the ALU returns (result 0, zero 1).
REQ-029 A requester that deasserts valid before ready is not granted; no state is kept for it.
REQ-030 Requests arriving in EXEC or RESP are not accepted; they wait with ready=0.

Reset
REQ-031 rst_n low immediately forces: state IDLE, prio 0, alu_enable 0, alu_op 0, alu_a 0, alu_b 0, rsp_result 0, rsp_zero 0, rsp0/1_valid 0, req0/1_ready 0, busy 0, op_count 0.
REQ-032 Reset during EXEC or RESP abandons the operation; no response is issued after release and op_count is not incremented.
REQ-033 First grant after reset release goes to requester 0 when both request.

Verification
REQ-034 Single op: req0 ADD a=0x0003 b=0x0004, ack on first rsp cycle -> ready0 in cycle 0, alu_enable high cycle 1, rsp0_valid cycle 2 with result 0x0007 zero 0, op_count 1.
REQ-035 Contention: both valid continuously, req0 SUB 5-5, req1 OR 0x00F0|0x000F -> order req0 (result 0x0000 zero 1), req1 (0x00FF), req0, req1; grants alternate.
REQ-036 Delayed ack: req1 XOR 0xAAAA^0x5555, ack held low 4 cycles -> rsp1_valid and rsp_result 0xFFFF stable 5 cycles, req0 ready stays 0 throughout.
REQ-037 Reset mid-op: assert rst_n low during EXEC of req0 EQ -> all outputs at reset values asynchronously, no rsp0_valid after release, op_count 0.
REQ-038 Wrap/edge: preload 65535 completed ops (or force op_count 0xFFFF), one more op -> op_count 0x0000; opcode 1111 -> result 0x0000, zero 1.
REQ-039 Stray ack: rsp1_ack pulsed in IDLE and during req0's RESP -> no state change, req0 response unaffected.

Source files
------------

// File: rtl/alu_arbiter_if.sv
// alu_arbiter_if: bundle of the request, response and shared-ALU signals of
// alu_arbiter.
//   slave  modport : the arbiter (drives ready, rsp_*, alu_*, busy, op_count)
//   master modport : the environment (requesters plus the combinational ALU)
//
// Handshake rules, in one place:
//   Request : an operation moves when reqN_valid && reqN_ready at a rising
//             clock edge. Ready never waits on anything but the arbiter's own
//             state and the current valids. A requester may drop valid before
//             it is granted; nothing is remembered for it.
//   Response: rspN_valid stays high, with rsp_result/rsp_zero stable, until
//             the owner raises rspN_ack at a rising edge. Acks from the other
//             requester, or acks with no response pending, have no effect.
interface alu_arbiter_if;
  logic        req0_valid;
  logic        req1_valid;
  logic        req0_ready;
  logic        req1_ready;
  logic [3:0]  req0_op;
  logic [3:0]  req1_op;
  logic [15:0] req0_a;
  logic [15:0] req0_b;
  logic [15:0] req1_a;
  logic [15:0] req1_b;
  logic        rsp0_valid;
  logic        rsp1_valid;
  logic        rsp0_ack;
  logic        rsp1_ack;
  logic [15:0] rsp_result;
  logic        rsp_zero;
  logic        alu_enable;
  logic [3:0]  alu_op;
  logic [15:0] alu_a;
  logic [15:0] alu_b;
  logic [15:0] alu_result;
  logic        alu_zero;
  logic        busy;
  logic [15:0] op_count;

  modport slave (
    input  req0_valid, req1_valid, req0_op, req1_op,
    input  req0_a, req0_b, req1_a, req1_b,
    input  rsp0_ack, rsp1_ack, alu_result, alu_zero,
    output req0_ready, req1_ready, rsp0_valid, rsp1_valid,
    output rsp_result, rsp_zero, alu_enable, alu_op, alu_a, alu_b,
    output busy, op_count
  );

  modport master (
    output req0_valid, req1_valid, req0_op, req1_op,
    output req0_a, req0_b, req1_a, req1_b,
    output rsp0_ack, rsp1_ack, alu_result, alu_zero,
    input  req0_ready, req1_ready, rsp0_valid, rsp1_valid,
    input  rsp_result, rsp_zero, alu_enable, alu_op, alu_a, alu_b,
    input  busy, op_count
  );
endinterface

// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one external combinational ALU between two requesters.
// One operation is in flight at a time: IDLE accepts, EXEC drives the ALU for
// a single cycle and captures its outputs, RESP holds the result for the
// owning requester until it acks. Grants alternate when both keep requesting.
// Ports:
//   clk      : rising-edge clock
//   rst_n    : asynchronous active-low reset
//   bus      : alu_arbiter_if.slave (requests, responses, ALU drive, status)
//   state_o  : current FSM state (0 IDLE, 1 EXEC, 2 RESP) for observation
module alu_arbiter (
  input  logic           clk,
  input  logic           rst_n,
  alu_arbiter_if.slave   bus,
  output logic [1:0]     state_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t      state_q;
  logic        prio_q;        // favoured requester on contention
  logic        owner_q;       // requester whose operation is in flight
  logic        alu_enable_q;
  logic [3:0]  alu_op_q;
  logic [15:0] alu_a_q;
  logic [15:0] alu_b_q;
  logic [15:0] rsp_result_q;
  logic        rsp_zero_q;
  logic [15:0] op_count_q;
  logic [15:0] op_count_d;

  logic grant1;
  logic ready0;
  logic ready1;
  logic owner_ack;

  always_comb begin
    // Requester 1 wins when it is the only one asking, or both ask and it is
    // favoured; otherwise a valid requester 0 wins.
    grant1     = bus.req1_valid && (!bus.req0_valid || prio_q);
    // Ready is gated by rst_n so that it drops the instant reset asserts,
    // even while a requester still holds valid.
    ready1     = rst_n && (state_q == IDLE) && grant1;
    ready0     = rst_n && (state_q == IDLE) && bus.req0_valid && !grant1;
    owner_ack  = owner_q ? bus.rsp1_ack : bus.rsp0_ack;
    op_count_d = op_count_q + 16'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      prio_q       <= 1'b0;
      owner_q      <= 1'b0;
      alu_enable_q <= 1'b0;
      alu_op_q     <= 4'd0;
      alu_a_q      <= 16'd0;
      alu_b_q      <= 16'd0;
      rsp_result_q <= 16'd0;
      rsp_zero_q   <= 1'b0;
      op_count_q   <= 16'd0;
    end else begin
      case (state_q)
        IDLE: begin
          if (ready0 || ready1) begin
            owner_q      <= ready1;
            alu_op_q     <= ready1 ? bus.req1_op : bus.req0_op;
            alu_a_q      <= ready1 ? bus.req1_a  : bus.req0_a;
            alu_b_q      <= ready1 ? bus.req1_b  : bus.req0_b;
            alu_enable_q <= 1'b1;
            state_q      <= EXEC;
          end
        end
        EXEC: begin
          // The ALU is combinational on alu_op/a/b, already stable this cycle.
          rsp_result_q <= bus.alu_result;
          rsp_zero_q   <= bus.alu_zero;
          alu_enable_q <= 1'b0;
          state_q      <= RESP;
        end
        RESP: begin
          if (owner_ack) begin
            prio_q     <= !owner_q;
            op_count_q <= op_count_d;
            state_q    <= IDLE;
          end
        end
        default: begin
          alu_enable_q <= 1'b0;
          state_q      <= IDLE;
        end
      endcase
    end
  end

  assign bus.req0_ready = ready0;
  assign bus.req1_ready = ready1;
  assign bus.rsp0_valid = (state_q == RESP) && !owner_q;
  assign bus.rsp1_valid = (state_q == RESP) &&  owner_q;
  assign bus.rsp_result = rsp_result_q;
  assign bus.rsp_zero   = rsp_zero_q;
  assign bus.alu_enable = alu_enable_q;
  assign bus.alu_op     = alu_op_q;
  assign bus.alu_a      = alu_a_q;
  assign bus.alu_b      = alu_b_q;
  assign bus.busy       = (state_q != IDLE);
  assign bus.op_count   = op_count_q;
  assign state_o        = state_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: drives directed and random traffic into alu_arbiter, acts as
// the shared combinational ALU, and checks every output each cycle against a
// transaction-level model plus hand-computed literal expectations.
module tb_alu_arbiter;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  alu_arbiter_if bus ();
  logic [1:0] dut_state;

  alu_arbiter dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .bus     (bus),
    .state_o (dut_state)
  );

  int n_chk = 0;
  int n_bad = 0;
  logic [15:0] preload_ofs = 16'd0;

  // Reference ALU behaviour: returns {zero, result}.
  function automatic logic [16:0] alu_ref(input logic [3:0] op,
                                          input logic [15:0] a,
                                          input logic [15:0] b);
    logic [15:0] r;
    case (op)
      4'd1:    r = a + b;
      4'd2:    r = a - b;
      4'd3:    r = a & b;
      4'd4:    r = a | b;
      4'd5:    r = a ^ b;
      4'd6:    r = ~a;
      4'd7:    r = a << 1;
      4'd8:    r = a >> 1;
      4'd9:    r = (a < b) ? 16'd1 : 16'd0;
      4'd10:   r = (a == b) ? 16'd1 : 16'd0;
      default: r = 16'd0;
    endcase
    return {(r == 16'd0), r};
  endfunction

  // The environment's ALU.
  assign {bus.alu_zero, bus.alu_result} = alu_ref(bus.alu_op, bus.alu_a, bus.alu_b);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs;
    bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
    bus.req0_op = 4'd0; bus.req1_op = 4'd0;
    bus.req0_a = 16'd0; bus.req0_b = 16'd0;
    bus.req1_a = 16'd0; bus.req1_b = 16'd0;
    bus.rsp0_ack = 1'b0; bus.rsp1_ack = 1'b0;
  endtask

  // Called at posedge+1; leaves reset released at posedge+2.
  task automatic do_reset;
    #1;
    rst_n = 1'b0;
    clear_inputs();
    preload_ofs = 16'd0;
    repeat (2) tick();
    #1;
    rst_n = 1'b1;
  endtask

  task automatic set_req(input int n, input logic [3:0] op,
                         input logic [15:0] a, input logic [15:0] b);
    if (n == 0) begin
      bus.req0_valid = 1'b1; bus.req0_op = op; bus.req0_a = a; bus.req0_b = b;
    end else begin
      bus.req1_valid = 1'b1; bus.req1_op = op; bus.req1_a = a; bus.req1_b = b;
    end
  endtask

  // ---------------- model + scoreboard ----------------
  // m_age: -1 when no operation is held, 0 on the cycle the ALU is driven,
  // 1.. while the result waits for its owner.
  logic [16:0] exp_q[$];
  int          m_age = -1;
  logic        m_prio = 1'b0;
  logic        m_owner = 1'b0;
  logic [3:0]  m_op = 4'd0;
  logic [15:0] m_a = 16'd0;
  logic [15:0] m_b = 16'd0;
  logic [15:0] m_res = 16'd0;
  logic        m_zero = 1'b0;
  logic [15:0] m_done = 16'd0;

  initial begin
    forever begin
      int g;
      logic [16:0] e;
      logic ack;
      @(negedge clk);
      if (!rst_n) begin
        m_age = -1; m_prio = 1'b0; m_owner = 1'b0;
        m_op = 4'd0; m_a = 16'd0; m_b = 16'd0;
        m_res = 16'd0; m_zero = 1'b0; m_done = 16'd0;
        exp_q.delete();
      end
      g = -1;
      if (rst_n && m_age < 0) begin
        if (bus.req0_valid && bus.req1_valid) g = m_prio ? 1 : 0;
        else if (bus.req0_valid) g = 0;
        else if (bus.req1_valid) g = 1;
      end
      chk("ready0", bus.req0_ready, g == 0);
      chk("ready1", bus.req1_ready, g == 1);
      chk("rsp0_valid", bus.rsp0_valid, (m_age >= 1) && !m_owner);
      chk("rsp1_valid", bus.rsp1_valid, (m_age >= 1) && m_owner);
      chk("busy", bus.busy, m_age >= 0);
      chk("alu_enable", bus.alu_enable, m_age == 0);
      chk("alu_op", bus.alu_op, m_op);
      chk("alu_a", bus.alu_a, m_a);
      chk("alu_b", bus.alu_b, m_b);
      chk("rsp_result", bus.rsp_result, m_res);
      chk("rsp_zero", bus.rsp_zero, m_zero);
      chk("op_count", bus.op_count, 16'(m_done + preload_ofs));
      chk("state_idle", dut_state == 2'd0, m_age < 0);
      if (rst_n) begin
        if (g >= 0) begin
          m_owner = (g == 1);
          m_op = (g == 1) ? bus.req1_op : bus.req0_op;
          m_a  = (g == 1) ? bus.req1_a  : bus.req0_a;
          m_b  = (g == 1) ? bus.req1_b  : bus.req0_b;
          exp_q.push_back(alu_ref(m_op, m_a, m_b));
          m_age = 0;
        end else if (m_age == 0) begin
          {m_zero, m_res} = alu_ref(m_op, m_a, m_b);
          m_age = 1;
        end else if (m_age >= 1) begin
          ack = m_owner ? bus.rsp1_ack : bus.rsp0_ack;
          if (ack) begin
            if (exp_q.size() == 0) begin
              chk("scoreboard_empty", 32'd1, 32'd0);
            end else begin
              e = exp_q.pop_front();
              chk("scoreboard", {bus.rsp_zero, bus.rsp_result}, e);
            end
            m_age = -1;
            m_prio = !m_owner;
            m_done = m_done + 16'd1;
          end else begin
            m_age = m_age + 1;
          end
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [17:0] rec_q[$];
    logic [17:0] want[4];
    clear_inputs();
    do_reset();

    // Single ADD, ack on first response cycle.
    tick();
    set_req(0, 4'd1, 16'h0003, 16'h0004);
    bus.rsp0_ack = 1'b1;
    #2 chk("single_ready0", bus.req0_ready, 1'b1);
    tick();
    bus.req0_valid = 1'b0;
    #2 chk("single_alu_en", bus.alu_enable, 1'b1);
    tick();
    #2 chk("single_rsp0_valid", bus.rsp0_valid, 1'b1);
    chk("single_result", bus.rsp_result, 16'h0007);
    chk("single_zero", bus.rsp_zero, 1'b0);
    tick();
    bus.rsp0_ack = 1'b0;
    #2 chk("single_count", bus.op_count, 16'd1);

    // Contention: both valid throughout, grants must alternate from req0.
    tick();
    do_reset();
    tick();
    set_req(0, 4'd2, 16'h0005, 16'h0005);
    set_req(1, 4'd4, 16'h00F0, 16'h000F);
    bus.rsp0_ack = 1'b1; bus.rsp1_ack = 1'b1;
    for (int c = 0; c < 13; c++) begin
      #2;
      if (bus.rsp0_valid) rec_q.push_back({1'b0, bus.rsp_zero, bus.rsp_result});
      if (bus.rsp1_valid) rec_q.push_back({1'b1, bus.rsp_zero, bus.rsp_result});
      tick();
    end
    clear_inputs();
    want[0] = {1'b0, 1'b1, 16'h0000};
    want[1] = {1'b1, 1'b0, 16'h00FF};
    want[2] = {1'b0, 1'b1, 16'h0000};
    want[3] = {1'b1, 1'b0, 16'h00FF};
    chk("contend_count", rec_q.size(), 4);
    for (int i = 0; i < 4; i++) begin
      if (i < rec_q.size()) chk("contend_order", rec_q[i], want[i]);
    end

    // Delayed ack: req1 XOR, ack low four response cycles; req0 waits.
    do_reset();
    tick();
    set_req(1, 4'd5, 16'hAAAA, 16'h5555);
    #2 chk("delay_ready1", bus.req1_ready, 1'b1);
    tick();
    bus.req1_valid = 1'b0;
    set_req(0, 4'd1, 16'h0001, 16'h0001);
    #2 chk("delay_ready0_exec", bus.req0_ready, 1'b0);
    for (int k = 0; k < 5; k++) begin
      tick();
      if (k == 4) bus.rsp1_ack = 1'b1;
      #2 chk("delay_rsp1_valid", bus.rsp1_valid, 1'b1);
      chk("delay_result", bus.rsp_result, 16'hFFFF);
      chk("delay_ready0", bus.req0_ready, 1'b0);
    end
    tick();
    bus.rsp1_ack = 1'b0;
    #2 chk("delay_ready0_after", bus.req0_ready, 1'b1);

    // Reset during EXEC abandons the operation.
    tick();
    do_reset();
    tick();
    set_req(0, 4'd10, 16'h0005, 16'h0005);
    #2 chk("rst_ready0", bus.req0_ready, 1'b1);
    tick();
    #1 chk("rst_in_exec", bus.alu_enable, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("rst_alu_en", bus.alu_enable, 1'b0);
    chk("rst_busy", bus.busy, 1'b0);
    chk("rst_alu_op", bus.alu_op, 4'd0);
    chk("rst_alu_a", bus.alu_a, 16'd0);
    chk("rst_ready0", bus.req0_ready, 1'b0);
    chk("rst_rsp0_valid", bus.rsp0_valid, 1'b0);
    tick();
    bus.req0_valid = 1'b0;
    tick();
    #1 rst_n = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick();
      #2 chk("rst_no_rsp", bus.rsp0_valid, 1'b0);
    end
    chk("rst_count", bus.op_count, 16'd0);

    // Stray acks from the non-owner.
    do_reset();
    tick();
    bus.rsp1_ack = 1'b1;
    #2 chk("stray_idle_busy", bus.busy, 1'b0);
    tick();
    bus.rsp1_ack = 1'b0;
    set_req(0, 4'd1, 16'h0100, 16'h0023);
    #2 chk("stray_ready0", bus.req0_ready, 1'b1);
    tick();
    bus.req0_valid = 1'b0;
    tick();
    bus.rsp1_ack = 1'b1;
    #2 chk("stray_rsp0", bus.rsp0_valid, 1'b1);
    tick();
    bus.rsp1_ack = 1'b0;
    #2 chk("stray_rsp0_held", bus.rsp0_valid, 1'b1);
    chk("stray_result", bus.rsp_result, 16'h0123);
    chk("stray_count0", bus.op_count, 16'd0);
    bus.rsp0_ack = 1'b1;
    tick();
    bus.rsp0_ack = 1'b0;
    #2 chk("stray_count1", bus.op_count, 16'd1);

    // Counter wrap plus undefined opcode.
    do_reset();
    tick();
    force dut.op_count_q = 16'hFFFF;
    preload_ofs = 16'hFFFF;
    #1 chk("wrap_preload", bus.op_count, 16'hFFFF);
    tick();
    release dut.op_count_q;
    set_req(0, 4'hF, 16'h1234, 16'h0001);
    bus.rsp0_ack = 1'b1;
    #2 chk("wrap_ready0", bus.req0_ready, 1'b1);
    tick();
    bus.req0_valid = 1'b0;
    tick();
    #2 chk("undef_result", bus.rsp_result, 16'h0000);
    chk("undef_zero", bus.rsp_zero, 1'b1);
    tick();
    bus.rsp0_ack = 1'b0;
    #2 chk("wrap_count", bus.op_count, 16'h0000);

    // Random traffic, checked by the model every cycle.
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      tick();
      bus.req0_valid = ($urandom_range(0, 9) < 6);
      bus.req1_valid = ($urandom_range(0, 9) < 6);
      bus.req0_op = 4'($urandom_range(0, 15));
      bus.req1_op = 4'($urandom_range(0, 15));
      bus.req0_a = $urandom_range(0, 1) ? 16'($urandom_range(0, 3)) : 16'($urandom);
      bus.req0_b = $urandom_range(0, 1) ? 16'($urandom_range(0, 3)) : 16'($urandom);
      bus.req1_a = $urandom_range(0, 1) ? 16'($urandom_range(0, 3)) : 16'($urandom);
      bus.req1_b = $urandom_range(0, 1) ? 16'($urandom_range(0, 3)) : 16'($urandom);
      bus.rsp0_ack = ($urandom_range(0, 1) == 1);
      bus.rsp1_ack = ($urandom_range(0, 1) == 1);
    end
    tick();
    clear_inputs();
    repeat (3) tick();

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
